// File: rtl/ptw_arb_pkg.sv
// Shared types and widths for the PTW request arbiter: FSM states,
// PTE flag bit positions and the packed walk-request payload.
package ptw_arb_pkg;

  localparam int unsigned VPN_W = 27;
  localparam int unsigned PPN_W = 20;
  localparam int unsigned FLG_W = 8;

  // PTE flag bit positions within resp_flags
  localparam int unsigned FLG_V = 0;
  localparam int unsigned FLG_R = 1;
  localparam int unsigned FLG_W_BIT = 2;
  localparam int unsigned FLG_X = 3;
  localparam int unsigned FLG_U = 4;
  localparam int unsigned FLG_G = 5;
  localparam int unsigned FLG_A = 6;
  localparam int unsigned FLG_D = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [VPN_W-1:0] addr;
    logic             fetch;
    logic             store;
    logic             pum;
    logic             mxr;
    logic [1:0]       prv;
  } ptw_req_t;

endpackage

// File: rtl/ptw_req_arbiter_if.sv
// Refill request/response channel between a TLB-side requester (master)
// and a page-table walker (slave); used on both sides of the arbiter.
interface ptw_req_arbiter_if;
  import ptw_arb_pkg::*;

  logic             req_valid;
  logic             req_ready;
  ptw_req_t         req;
  logic             resp_valid;
  logic [PPN_W-1:0] resp_ppn;
  logic [FLG_W-1:0] resp_flags;
  logic             invalidate;

  modport master (
    output req_valid, req,
    input  req_ready, resp_valid, resp_ppn, resp_flags, invalidate
  );

  modport slave (
    input  req_valid, req,
    output req_ready, resp_valid, resp_ppn, resp_flags, invalidate
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  assign grant = (&valid) ? (prio ? 2'b10 : 2'b01) : valid;

endmodule

// File: rtl/ptw_req_arbiter.sv
// Shares one PTW port between ITLB (r0) and DTLB (r1): round-robin grant,
// registered request toward the PTW, response routed back to the owner.
module ptw_req_arbiter
  import ptw_arb_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  ptw_req_arbiter_if.slave    r0,
  ptw_req_arbiter_if.slave    r1,
  ptw_req_arbiter_if.master   ptw,
  output logic                owner,
  output logic                spurious_resp
);

  arb_state_e state;
  logic       prio;
  ptw_req_t   req_q;
  logic       req_valid_q;
  logic [1:0] grant;
  logic       resp_hit;

  rr_arb2 u_rr_arb2 (
    .valid ({r1.req_valid, r0.req_valid}),
    .prio  (prio),
    .grant (grant)
  );

  // Requests are only taken while no walk is in flight
  assign r0.req_ready = (state == ST_IDLE) && grant[0];
  assign r1.req_ready = (state == ST_IDLE) && grant[1];

  assign ptw.req_valid = req_valid_q;
  assign ptw.req       = req_q;

  // Response forwarded with zero latency to the walk owner only
  assign resp_hit      = (state == ST_WAIT) && ptw.resp_valid;
  assign r0.resp_valid = resp_hit && !owner;
  assign r1.resp_valid = resp_hit && owner;
  assign r0.resp_ppn   = ptw.resp_ppn;
  assign r1.resp_ppn   = ptw.resp_ppn;
  assign r0.resp_flags = ptw.resp_flags;
  assign r1.resp_flags = ptw.resp_flags;
  assign r0.invalidate = ptw.invalidate;
  assign r1.invalidate = ptw.invalidate;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      prio          <= 1'b0;
      owner         <= 1'b0;
      spurious_resp <= 1'b0;
      req_q         <= '0;
      req_valid_q   <= 1'b0;
    end else begin
      // Any response not answering an accepted walk is sticky-flagged
      if (ptw.resp_valid && (state != ST_WAIT)) begin
        spurious_resp <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            req_q       <= grant[1] ? r1.req : r0.req;
            owner       <= grant[1];
            req_valid_q <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ptw.req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ptw.resp_valid) begin
            prio  <= ~owner;
            state <= ST_IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_ptw_req_arbiter;
  import ptw_arb_pkg::*;

  logic clock;
  logic reset;
  logic owner;
  logic spurious_resp;

  ptw_req_arbiter_if r0_if ();
  ptw_req_arbiter_if r1_if ();
  ptw_req_arbiter_if ptw_if ();

  ptw_req_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .r0            (r0_if),
    .r1            (r1_if),
    .ptw           (ptw_if),
    .owner         (owner),
    .spurious_resp (spurious_resp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    r0_if.req_valid   = 1'b0;
    r0_if.req         = '0;
    r1_if.req_valid   = 1'b0;
    r1_if.req         = '0;
    ptw_if.req_ready  = 1'b0;
    ptw_if.resp_valid = 1'b0;
    ptw_if.resp_ppn   = '0;
    ptw_if.resp_flags = '0;
    ptw_if.invalidate = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  // One row = one clock cycle: inputs applied, then outputs expected that cycle
  typedef struct packed {
    logic             rst;
    logic             v0;
    logic             v1;
    logic [VPN_W-1:0] a0;
    logic [VPN_W-1:0] a1;
    logic             f0;
    logic             prdy;
    logic             rv;
    logic [PPN_W-1:0] ppn;
    logic [FLG_W-1:0] flg;
    logic             inv;
    logic             rdy0;
    logic             rdy1;
    logic             pv;
    logic [VPN_W-1:0] paddr;
    logic             rv0;
    logic             rv1;
    logic             own;
    logic             spur;
  } vec_t;

  localparam int unsigned NV = 15;
  vec_t tbl [NV];

  task automatic drive_vec(input vec_t v);
    reset             = !v.rst;
    r0_if.req_valid   = v.v0;
    r0_if.req         = '0;
    r0_if.req.addr    = v.a0;
    r0_if.req.fetch   = v.f0;
    r1_if.req_valid   = v.v1;
    r1_if.req         = '0;
    r1_if.req.addr    = v.a1;
    ptw_if.req_ready  = v.prdy;
    ptw_if.resp_valid = v.rv;
    ptw_if.resp_ppn   = v.ppn;
    ptw_if.resp_flags = v.flg;
    ptw_if.invalidate = v.inv;
  endtask

  function automatic ptw_req_t rand_req();
    ptw_req_t r;
    r.addr  = VPN_W'($urandom);
    r.fetch = 1'($urandom);
    r.store = 1'($urandom);
    r.pum   = 1'($urandom);
    r.mxr   = 1'($urandom);
    r.prv   = 2'($urandom);
    return r;
  endfunction

  // Transaction-level reference: at most one walk in flight
  typedef struct {
    bit       who;
    ptw_req_t pay;
    bit       sent;
  } walk_t;

  walk_t    walk_q[$];
  bit       favour;
  bit       m_owner;
  bit       m_spur;
  ptw_req_t last_pay;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{v0:1'b1, a0:27'h1234567, f0:1'b1, prdy:1'b1, rdy0:1'b1, default:'0};
    tbl[1]  = '{prdy:1'b1, pv:1'b1, paddr:27'h1234567, default:'0};
    tbl[2]  = '{prdy:1'b1, paddr:27'h1234567, default:'0};
    tbl[3]  = '{prdy:1'b1, paddr:27'h1234567, default:'0};
    tbl[4]  = '{prdy:1'b1, rv:1'b1, ppn:20'hABCDE, flg:8'hCF, paddr:27'h1234567, rv0:1'b1, default:'0};
    tbl[5]  = '{v0:1'b1, v1:1'b1, a0:27'h1, a1:27'h0ABCDEF, rdy1:1'b1, paddr:27'h1234567, default:'0};
    tbl[6]  = '{v0:1'b1, a0:27'h1, pv:1'b1, paddr:27'h0ABCDEF, own:1'b1, default:'0};
    tbl[7]  = '{v0:1'b1, a0:27'h1, prdy:1'b1, rv:1'b1, ppn:20'h11111, flg:8'h01, pv:1'b1,
                paddr:27'h0ABCDEF, own:1'b1, default:'0};
    tbl[8]  = '{v0:1'b1, a0:27'h1, inv:1'b1, paddr:27'h0ABCDEF, own:1'b1, spur:1'b1, default:'0};
    tbl[9]  = '{v0:1'b1, a0:27'h1, rv:1'b1, ppn:20'h0FFFF, flg:8'hFF, inv:1'b1, paddr:27'h0ABCDEF,
                rv1:1'b1, own:1'b1, spur:1'b1, default:'0};
    tbl[10] = '{v0:1'b1, a0:27'h7FFFFFF, v1:1'b1, a1:27'h5555555, rdy0:1'b1, paddr:27'h0ABCDEF,
                own:1'b1, spur:1'b1, default:'0};
    tbl[11] = '{v1:1'b1, a1:27'h5555555, pv:1'b1, paddr:27'h7FFFFFF, spur:1'b1, default:'0};
    tbl[12] = '{rst:1'b1, v1:1'b1, a1:27'h5555555, pv:1'b1, paddr:27'h7FFFFFF, spur:1'b1, default:'0};
    tbl[13] = '{rv:1'b1, ppn:20'h12345, flg:8'h3C, default:'0};
    tbl[14] = '{spur:1'b1, default:'0};

    do_reset();
    #1;
    chk("rst_ptw_valid", ptw_if.req_valid, 1'b0);
    chk("rst_ptw_req", ptw_if.req, '0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_spur", spurious_resp, 1'b0);
    chk("rst_rv0", r0_if.resp_valid, 1'b0);
    chk("rst_rv1", r1_if.resp_valid, 1'b0);
    cyc();

    // Directed vector table
    for (int i = 0; i < int'(NV); i++) begin
      drive_vec(tbl[i]);
      #1;
      chk($sformatf("vec%0d r0_ready", i), r0_if.req_ready, tbl[i].rdy0);
      chk($sformatf("vec%0d r1_ready", i), r1_if.req_ready, tbl[i].rdy1);
      chk($sformatf("vec%0d ptw_valid", i), ptw_if.req_valid, tbl[i].pv);
      chk($sformatf("vec%0d ptw_addr", i), ptw_if.req.addr, tbl[i].paddr);
      chk($sformatf("vec%0d r0_resp_valid", i), r0_if.resp_valid, tbl[i].rv0);
      chk($sformatf("vec%0d r1_resp_valid", i), r1_if.resp_valid, tbl[i].rv1);
      chk($sformatf("vec%0d owner", i), owner, tbl[i].own);
      chk($sformatf("vec%0d spurious", i), spurious_resp, tbl[i].spur);
      chk($sformatf("vec%0d r0_inval", i), r0_if.invalidate, tbl[i].inv);
      chk($sformatf("vec%0d r1_inval", i), r1_if.invalidate, tbl[i].inv);
      if (tbl[i].rv0) begin
        chk($sformatf("vec%0d r0_ppn", i), r0_if.resp_ppn, tbl[i].ppn);
        chk($sformatf("vec%0d r0_flags", i), r0_if.resp_flags, tbl[i].flg);
      end
      if (tbl[i].rv1) begin
        chk($sformatf("vec%0d r1_ppn", i), r1_if.resp_ppn, tbl[i].ppn);
        chk($sformatf("vec%0d r1_flags", i), r1_if.resp_flags, tbl[i].flg);
      end
      cyc();
    end

    // Both requesters held: grants must alternate r0, r1, r0 after reset
    do_reset();
    r0_if.req_valid  = 1'b1;
    r0_if.req.addr   = 27'h0000AAA;
    r1_if.req_valid  = 1'b1;
    r1_if.req.addr   = 27'h0000BBB;
    ptw_if.req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit seen;
      bit who;
      seen = 1'b0;
      who  = (k % 2) == 1;
      for (int t = 0; t < 8 && !seen; t++) begin
        #1;
        if (ptw_if.req_valid === 1'b1) seen = 1'b1;
        cyc();
      end
      chk($sformatf("alt%0d issued", k), seen, 1'b1);
      ptw_if.resp_valid = 1'b1;
      #1;
      chk($sformatf("alt%0d owner", k), owner, who);
      chk($sformatf("alt%0d addr", k), ptw_if.req.addr, who ? 27'h0000BBB : 27'h0000AAA);
      chk($sformatf("alt%0d r0_resp", k), r0_if.resp_valid, !who);
      chk($sformatf("alt%0d r1_resp", k), r1_if.resp_valid, who);
      cyc();
      ptw_if.resp_valid = 1'b0;
    end

    // PTW stalls in ISSUE: request fields stay put, no new request taken
    r1_if.req_valid  = 1'b0;
    r0_if.req_valid  = 1'b1;
    r0_if.req.addr   = 27'h2468ACE;
    ptw_if.req_ready = 1'b0;
    #1;
    chk("stall grant_r0", r0_if.req_ready, 1'b1);
    cyc();
    r0_if.req.addr  = 27'h1357BDF;
    r1_if.req_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("stall%0d valid", s), ptw_if.req_valid, 1'b1);
      chk($sformatf("stall%0d addr", s), ptw_if.req.addr, 27'h2468ACE);
      chk($sformatf("stall%0d r0_ready", s), r0_if.req_ready, 1'b0);
      chk($sformatf("stall%0d r1_ready", s), r1_if.req_ready, 1'b0);
      cyc();
    end
    ptw_if.req_ready = 1'b1;
    r0_if.req_valid  = 1'b0;
    r1_if.req_valid  = 1'b0;
    cyc();
    ptw_if.req_ready  = 1'b0;
    ptw_if.resp_valid = 1'b1;
    #1;
    chk("stall r0_resp", r0_if.resp_valid, 1'b1);
    cyc();
    ptw_if.resp_valid = 1'b0;

    // Reset during WAIT with prio on r1: ownership dropped, r0 wins next
    r1_if.req_valid  = 1'b1;
    ptw_if.req_ready = 1'b1;
    #1;
    chk("rstwait r1_grant", r1_if.req_ready, 1'b1);
    cyc();
    r1_if.req_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    r0_if.req_valid = 1'b1;
    r1_if.req_valid = 1'b1;
    #1;
    chk("rstwait ptw_valid", ptw_if.req_valid, 1'b0);
    chk("rstwait owner", owner, 1'b0);
    chk("rstwait r0_ready", r0_if.req_ready, 1'b1);
    chk("rstwait r1_ready", r1_if.req_ready, 1'b0);
    cyc();

    // Randomized run against the transaction model
    do_reset();
    walk_q.delete();
    favour   = 1'b0;
    m_owner  = 1'b0;
    m_spur   = 1'b0;
    last_pay = '0;
    for (int c = 0; c < 3000; c++) begin
      bit idle, gv, gwho, busy_sent, v0, v1, rsp;
      reset             = ($urandom_range(0, 199) != 0);
      r0_if.req_valid   = 1'($urandom);
      r0_if.req         = rand_req();
      r1_if.req_valid   = 1'($urandom);
      r1_if.req         = rand_req();
      ptw_if.req_ready  = 1'($urandom);
      ptw_if.resp_valid = ($urandom_range(0, 3) == 0);
      ptw_if.resp_ppn   = PPN_W'($urandom);
      ptw_if.resp_flags = FLG_W'($urandom);
      ptw_if.invalidate = ($urandom_range(0, 7) == 0);
      #1;
      v0        = r0_if.req_valid;
      v1        = r1_if.req_valid;
      rsp       = ptw_if.resp_valid;
      idle      = (walk_q.size() == 0);
      gv        = idle && (v0 || v1);
      gwho      = (v0 && v1) ? favour : v1;
      busy_sent = !idle && walk_q[0].sent;
      chk("rnd r0_ready", r0_if.req_ready, gv && !gwho);
      chk("rnd r1_ready", r1_if.req_ready, gv && gwho);
      chk("rnd ptw_valid", ptw_if.req_valid, !idle && !walk_q[0].sent);
      chk("rnd ptw_req", ptw_if.req, last_pay);
      chk("rnd r0_resp", r0_if.resp_valid, busy_sent && rsp && !walk_q[0].who);
      chk("rnd r1_resp", r1_if.resp_valid, busy_sent && rsp && walk_q[0].who);
      chk("rnd owner", owner, m_owner);
      chk("rnd spurious", spurious_resp, m_spur);
      chk("rnd inval", {r1_if.invalidate, r0_if.invalidate}, {2{ptw_if.invalidate}});
      if (busy_sent && rsp) begin
        chk("rnd ppn", walk_q[0].who ? r1_if.resp_ppn : r0_if.resp_ppn, ptw_if.resp_ppn);
        chk("rnd flags", walk_q[0].who ? r1_if.resp_flags : r0_if.resp_flags, ptw_if.resp_flags);
      end
      if (!reset) begin
        walk_q.delete();
        favour   = 1'b0;
        m_owner  = 1'b0;
        m_spur   = 1'b0;
        last_pay = '0;
      end else begin
        if (rsp && !busy_sent) m_spur = 1'b1;
        if (gv) begin
          walk_t w;
          w.who  = gwho;
          w.pay  = gwho ? r1_if.req : r0_if.req;
          w.sent = 1'b0;
          walk_q.push_back(w);
          m_owner  = gwho;
          last_pay = w.pay;
        end else if (!idle && !walk_q[0].sent && ptw_if.req_ready) begin
          walk_q[0].sent = 1'b1;
        end else if (busy_sent && rsp) begin
          favour = !walk_q[0].who;
          void'(walk_q.pop_front());
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
